// File: rtl/it_seq_ctrl.sv
// ============================================================================
// it_seq_ctrl -- Thumb-2 IT (If-Then) block sequencer
//
// Tracks the 8-bit ITSTATE register across an IT block. It loads ITSTATE from
// a legal IT instruction, advances it once for each instruction issued inside
// the block, and evaluates the condition of the current slot against the
// APSR flags. The result tells the pipeline whether to execute the current
// instruction or to demote it to a NOP.
//
// Optional feature (compile-time macro IT_SEQ_CTRL_ERR_EN):
//   defined   -> an illegal IT raises it_err for one cycle, and err_cnt
//                counts these events, saturating at 8'hFF.
//   undefined -> it_err and err_cnt are tied to 0 and no counter register is
//                built. An illegal IT is still demoted (hint_or_exc = 0).
//
// Ports
//   clk              in   1  core clock, rising edge
//   rst_n            in   1  asynchronous active-low reset
//   inst_valid       in   1  an instruction issues this cycle
//   inst             in  32  issued instruction (16-bit encodings in [31:16])
//   apsr             in   5  flags {N,Z,C,V,Q} at [4:0]
//   flush            in   1  branch/exception entry, discards the IT block
//   itstate_wr       in   1  restore ITSTATE (exception return)
//   itstate_wr_data  in   8  ITSTATE value to restore
//   itstate          out  8  current ITSTATE, IT[7:0]
//   in_it_blk        out  1  IT[3:0] != 0
//   cur_cond         out  4  IT[7:4] inside a block, else 4'b1110 (AL)
//   hint_or_exc      out  1  1 = execute, 0 = demote to NOP
//   it_remain        out  3  slots left including the current one, 0 outside
//   it_err           out  1  illegal IT seen this cycle
//   err_cnt          out  8  saturating illegal-IT count
// ============================================================================
module it_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    input  logic [4:0]  apsr,
    input  logic        flush,
    input  logic        itstate_wr,
    input  logic [7:0]  itstate_wr_data,
    output logic [7:0]  itstate,
    output logic        in_it_blk,
    output logic [3:0]  cur_cond,
    output logic        hint_or_exc,
    output logic [2:0]  it_remain,
    output logic        it_err,
    output logic [7:0]  err_cnt
);

    // ------------------------------------------------------------------------
    // State encoding. The state is implied by ITSTATE: a non-zero mask field
    // means that a block is in progress. The ITSTATE register is therefore
    // the only state element, and the enum is decoded from it.
    // ------------------------------------------------------------------------
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BLOCK = 1'b1
    } state_t;

    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    logic [7:0] itstate_reg;
    logic [7:0] itstate_next;
    state_t     state;

    // Instruction decode
    logic       is_it;
    logic [3:0] it_firstcond;
    logic [3:0] it_mask;
    logic       it_issue;
    logic       it_illegal;
    logic       it_load;

    // ITSTATE value after one in-block instruction
    logic [7:0] itstate_adv;

    // The low halfword and the Q flag play no part in IT sequencing.
    logic       unused_bits;
    assign unused_bits = ^{inst[15:0], apsr[0]};

    // ------------------------------------------------------------------------
    // Condition evaluation. f = {N,Z,C,V,Q}.
    // ------------------------------------------------------------------------
    function automatic logic cond_pass(input logic [3:0] c, input logic [4:0] f);
        logic n_f;
        logic z_f;
        logic c_f;
        logic v_f;
        logic pass;
        n_f  = f[4];
        z_f  = f[3];
        c_f  = f[2];
        v_f  = f[1];
        pass = 1'b1;
        case (c)
            4'b0000: pass = z_f;                         // EQ
            4'b0001: pass = !z_f;                        // NE
            4'b0010: pass = c_f;                         // CS
            4'b0011: pass = !c_f;                        // CC
            4'b0100: pass = n_f;                         // MI
            4'b0101: pass = !n_f;                        // PL
            4'b0110: pass = v_f;                         // VS
            4'b0111: pass = !v_f;                        // VC
            4'b1000: pass = c_f && !z_f;                 // HI
            4'b1001: pass = !c_f || z_f;                 // LS
            4'b1010: pass = (n_f == v_f);                // GE
            4'b1011: pass = (n_f != v_f);                // LT
            4'b1100: pass = !z_f && (n_f == v_f);        // GT
            4'b1101: pass = z_f || (n_f != v_f);         // LE
            default: pass = 1'b1;                        // AL / 1111
        endcase
        return pass;
    endfunction

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    // IT is 0xBF with a non-zero mask. A zero mask in this encoding space is
    // a hint instruction (NOP, YIELD, ...), so it is treated as ordinary.
    assign it_firstcond = inst[23:20];
    assign it_mask      = inst[19:16];
    assign is_it        = (inst[31:24] == 8'hBF) && (it_mask != 4'h0);
    assign it_issue     = inst_valid && is_it;

    assign state = (itstate_reg[3:0] != 4'h0) ? ST_BLOCK : ST_IDLE;

    // An IT inside a block is unpredictable, and so is firstcond = 1111.
    // Both are demoted and flagged.
    assign it_illegal = it_issue && ((state == ST_BLOCK) || (it_firstcond == COND_NV));
    assign it_load    = it_issue && !it_illegal && (state == ST_IDLE);

    // The last slot is reached when the bits below the terminating 1 are
    // exhausted (IT[2:0] == 0). Otherwise IT[4:0] shifts left, which moves
    // the next mask bit into the condition LSB while IT[7:5] stay fixed.
    assign itstate_adv = (itstate_reg[2:0] == 3'b000) ? 8'h00
                       : {itstate_reg[7:5], itstate_reg[3:0], 1'b0};

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            itstate_reg <= 8'h00;
        end else begin
            itstate_reg <= itstate_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic: flush > restore > IT load > advance
    // ------------------------------------------------------------------------
    always_comb begin
        itstate_next = itstate_reg;
        if (flush) begin
            itstate_next = 8'h00;
        end else if (itstate_wr) begin
            itstate_next = itstate_wr_data;
        end else if (inst_valid) begin
            case (state)
                ST_IDLE: begin
                    // An illegal IT in IDLE (firstcond = 1111) leaves
                    // ITSTATE untouched.
                    if (it_load) begin
                        itstate_next = {it_firstcond, it_mask};
                    end
                end
                ST_BLOCK: begin
                    // Every issued instruction, including an illegal nested
                    // IT, consumes one slot.
                    itstate_next = itstate_adv;
                end
                default: itstate_next = itstate_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign itstate   = itstate_reg;
    assign in_it_blk = (state == ST_BLOCK);
    assign cur_cond  = in_it_blk ? itstate_reg[7:4] : COND_AL;

    // Outside a block cur_cond is AL, so an IT issued from IDLE executes.
    assign hint_or_exc = cond_pass(cur_cond, apsr) && !it_illegal;

    // The position of the lowest set mask bit gives the slots remaining.
    always_comb begin
        it_remain = 3'd0;
        casez (itstate_reg[3:0])
            4'b???1: it_remain = 3'd4;
            4'b??10: it_remain = 3'd3;
            4'b?100: it_remain = 3'd2;
            4'b1000: it_remain = 3'd1;
            default: it_remain = 3'd0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Illegal-IT reporting
    // ------------------------------------------------------------------------
`ifdef IT_SEQ_CTRL_ERR_EN
    logic [7:0] err_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= 8'h00;
        end else if (it_illegal && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign it_err  = it_illegal;
    assign err_cnt = err_cnt_reg;
`else
    assign it_err  = 1'b0;
    assign err_cnt = 8'h00;
`endif

endmodule

// File: doc/it_seq_ctrl.md
IT_SEQ_CTRL -- requirements
Module: it_seq_ctrl

Interface
REQ-001 SHALL provide clk  input  1  core clock; all state updates on rising edge.
REQ-002 SHALL provide rst_n  input  1  reset; asynchronous and active-low.
REQ-003 SHALL provide inst_valid  input  1  an instruction issues this cycle.
REQ-004 SHALL provide inst  input  32  issued instruction; a 16-bit encoding occupies [31:16].
REQ-005 SHALL provide apsr  input  5  flags {N,Z,C,V,Q} at [4:0].
REQ-006 SHALL provide flush  input  1  branch or exception entry; discards the IT block.
REQ-007 SHALL provide itstate_wr  input  1  restores ITSTATE from exception return.
REQ-008 SHALL provide itstate_wr_data  input  8  ITSTATE value to restore.
REQ-009 SHALL provide itstate  output  8  current ITSTATE, IT[7:0].
REQ-010 SHALL provide in_it_blk  output  1  high when IT[3:0]!=0.
REQ-011 SHALL provide cur_cond  output  4  IT[7:4] when in_it_blk, else 4'b1110 (AL).
REQ-012 SHALL provide hint_or_exc  output  1  1=execute, 0=demote to NOP (condition failed).
REQ-013 SHALL provide it_remain  output  3  instructions left in block including current; 0 outside.
REQ-014 SHALL provide it_err  output  1  one-cycle flag for an illegal IT.
REQ-015 SHALL provide err_cnt  output  8  saturating illegal-IT count.

Function
REQ-016 SHALL decode IT as inst[31:24]==8'hBF and inst[19:16]!=0 (firstcond=inst[23:20], mask=inst[19:16]).
REQ-017 SHALL use two states: IDLE (IT[3:0]==0) and BLOCK (IT[3:0]!=0).
REQ-018 IDLE: a valid IT SHALL load itstate={firstcond,mask} at the next edge; hint_or_exc=1 for the IT itself.
REQ-019 BLOCK: each valid instruction SHALL advance ITSTATE at the next edge: if IT[2:0]==0 then itstate=0 (to IDLE), else IT[4:0]=IT[4:0]<<1 and IT[7:5] is held.
REQ-020 hint_or_exc SHALL be combinational from registered cur_cond and current apsr, using the ARMv7-M table: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); 1110/1111 true.
REQ-021 it_remain SHALL be 4/3/2/1 for IT[0]=1 / IT[1:0]=10 / IT[2:0]=100 / IT[3:0]=1000.
REQ-022 An IT decoded in BLOCK, or with firstcond==4'b1111, SHALL be illegal: hint_or_exc=0, it_err=1 for that cycle; in BLOCK, ITSTATE advances per REQ-019; in IDLE, ITSTATE stays 0.
REQ-023 When inst_valid=0, ITSTATE SHALL hold and it_err SHALL be 0.
REQ-024 Next-state priority SHALL be flush (itstate=0) > itstate_wr (itstate=itstate_wr_data) > IT load > advance.
REQ-025 err_cnt SHALL increment on each it_err and saturate at 8'hFF.

Reset
REQ-026 rst_n low SHALL asynchronously force itstate=0 and err_cnt=0, giving in_it_blk=0, cur_cond=4'b1110, hint_or_exc=1, it_remain=0, it_err=0.
REQ-027 Reset asserted mid-block SHALL abandon the block; the first instruction after release SHALL execute unconditionally.

Configuration
REQ-028 With IT_SEQ_CTRL_ERR_EN defined, REQ-022 error flagging and the REQ-025 counter SHALL be present.
REQ-029 Without IT_SEQ_CTRL_ERR_EN, it_err and err_cnt SHALL be constant 0 and no counter register SHALL exist; an illegal IT SHALL still produce hint_or_exc=0 and the same ITSTATE behaviour.

Verification
REQ-030 SHALL cover reset: rst_n=0 -> itstate=8'h00, cur_cond=4'b1110, hint_or_exc=1, err_cnt=0.
REQ-031 SHALL cover a single-slot IT: 0xBF08xxxx, then one instruction with Z=1 -> cur_cond=0000, it_remain=1, hint_or_exc=1; next instruction -> in_it_blk=0.
REQ-032 SHALL cover ITTE EQ: 0xBF06xxxx, then three instructions with Z=0 -> cur_cond 0000,0000,0001, hint_or_exc 0,0,1, it_remain 3,2,1, then itstate=0.
REQ-033 SHALL cover flush mid-block: flush=1 after the first of three slots -> itstate=0 and the next instruction has hint_or_exc=1.
REQ-034 SHALL cover a nested IT: IT issued while it_remain=2 -> it_err=1 for one cycle, err_cnt 0->1, hint_or_exc=0, it_remain=1 next (macro on); with the macro off, it_err=0.
REQ-035 SHALL cover restore priority: itstate_wr=1 with data 8'h18 in the same cycle as IT 0xBF04xxxx -> itstate=8'h18.
